exc_entry_seq: RTL and testbench

//  Exception/ERET sequencer: counterpart of the CP0 register file. CP0 records the

---
 rtl/exc_entry_seq.sv | 131 +++++++++++++
 tb/tb_exc_entry_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/exc_entry_seq.sv
// Exception/ERET sequencer: prioritises exception, interrupt and ERET requests,
// pulses the CP0 update, flushes the pipeline and offers the fetch redirect.
module exc_entry_seq #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
   parameter int unsigned FLUSH_CYCLES = 2,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exc_valid,
   input  logic [4:0]       exc_code,
   input  logic [31:0]      exc_pc,
   input  logic             exc_in_delay,
   input  logic             int_req,
   input  logic             status_ie,
   input  logic             status_exl,
   input  logic             eret_req,
   input  logic [31:0]      epc_in,
   input  logic             fetch_ready,
   output logic             cp0_commit,
   output logic             cp0_epc_we,
   output logic [4:0]       cp0_code,
   output logic [31:0]      cp0_epc,
   output logic             cp0_bd,
   output logic             cp0_clr_exl,
   output logic             flush,
   output logic             stall,
   output logic             redir_valid,
   output logic [31:0]      redir_addr,
   output logic [CNT_W-1:0] exc_count
);

   localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIR} state_t;

   state_t            r_state, w_next;
   logic              w_take_exc, w_take_eret;
   logic [FC_W-1:0]   r_flush_cnt;
   logic [31:0]       r_target;
   logic              r_commit, r_clr_exl, r_epc_we, r_bd;
   logic [4:0]        r_code;
   logic [31:0]       r_epc, r_redir_addr;
   logic [CNT_W-1:0]  r_count;

   // NOTE: reset is synchronous and active-low; it is only seen on a rising clk edge.
   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_next      = r_state;
      w_take_exc  = 1'b0;
      w_take_eret = 1'b0;
      flush       = 1'b0;
      stall       = 1'b1;
      redir_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            stall       = 1'b0;
            w_take_exc  = exc_valid | (int_req & status_ie & !status_exl);
            w_take_eret = eret_req & !w_take_exc;
            if (w_take_exc || w_take_eret) w_next = S_FLUSH;
         end
         S_FLUSH: begin
            flush = 1'b1;
            if (r_flush_cnt == '0) w_next = S_REDIR;
         end
         S_REDIR: begin
            redir_valid = 1'b1;
            if (fetch_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_flush_cnt  <= '0;
         r_target     <= '0;
         r_commit     <= 1'b0;
         r_clr_exl    <= 1'b0;
         r_epc_we     <= 1'b0;
         r_bd         <= 1'b0;
         r_code       <= '0;
         r_epc        <= '0;
         r_redir_addr <= '0;
         r_count      <= '0;
      end else begin
         r_commit  <= 1'b0;
         r_clr_exl <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_take_exc) begin
                  r_commit    <= 1'b1;
                  r_code      <= exc_valid ? exc_code : 5'h00;
                  r_epc       <= exc_in_delay ? (exc_pc - 32'd4) : exc_pc;
                  r_bd        <= exc_in_delay;
                  r_epc_we    <= !status_exl;
                  r_target    <= EXC_VECTOR;
                  r_flush_cnt <= FC_LOAD;
                  if (r_count != '1) r_count <= r_count + CNT_W'(1);
               end else if (w_take_eret) begin
                  r_clr_exl   <= 1'b1;
                  r_target    <= epc_in;
                  r_flush_cnt <= FC_LOAD;
               end
            end
            S_FLUSH: begin
               if (r_flush_cnt == '0) r_redir_addr <= r_target;
               else                   r_flush_cnt  <= r_flush_cnt - FC_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign cp0_commit  = r_commit;
   assign cp0_clr_exl = r_clr_exl;
   assign cp0_epc_we  = r_epc_we;
   assign cp0_code    = r_code;
   assign cp0_epc     = r_epc;
   assign cp0_bd      = r_bd;
   assign redir_addr  = r_redir_addr;
   assign exc_count   = r_count;

endmodule

// File: tb/tb_exc_entry_seq.sv
// Directed bench for exc_entry_seq: table of single requests followed by
// hand-written ERET back-pressure, reset-abort and counter saturation sequences.
module tb_exc_entry_seq;

   localparam int CNT_W = 4;
   localparam logic [31:0] VEC = 32'hBFC0_0380;

   logic             clk = 1'b0;
   logic             reset;
   logic             exc_valid, exc_in_delay, int_req, status_ie, status_exl;
   logic             eret_req, fetch_ready;
   logic [4:0]       exc_code;
   logic [31:0]      exc_pc, epc_in;
   logic             cp0_commit, cp0_epc_we, cp0_bd, cp0_clr_exl;
   logic             flush, stall, redir_valid;
   logic [4:0]       cp0_code;
   logic [31:0]      cp0_epc, redir_addr;
   logic [CNT_W-1:0] exc_count;

   int n_cmp = 0;
   int n_bad = 0;
   logic [CNT_W-1:0] exp_count;

   exc_entry_seq #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .exc_valid(exc_valid), .exc_code(exc_code), .exc_pc(exc_pc),
      .exc_in_delay(exc_in_delay), .int_req(int_req), .status_ie(status_ie),
      .status_exl(status_exl), .eret_req(eret_req), .epc_in(epc_in),
      .fetch_ready(fetch_ready),
      .cp0_commit(cp0_commit), .cp0_epc_we(cp0_epc_we), .cp0_code(cp0_code),
      .cp0_epc(cp0_epc), .cp0_bd(cp0_bd), .cp0_clr_exl(cp0_clr_exl),
      .flush(flush), .stall(stall), .redir_valid(redir_valid),
      .redir_addr(redir_addr), .exc_count(exc_count)
   );

   always #5 clk = ~clk;

   // kind: 0 = ignored, 1 = exception/interrupt taken, 2 = ERET taken
   typedef struct {
      string       name;
      logic        ev;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic        irq, ie, exl, eret;
      logic [31:0] epc_in;
      int          kind;
      logic [4:0]  e_code;
      logic [31:0] e_epc;
      logic        e_bd, e_we;
      logic [31:0] e_target;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      exc_valid = 0; exc_code = 0; exc_pc = 0; exc_in_delay = 0;
      int_req = 0; status_ie = 0; status_exl = 0; eret_req = 0; epc_in = 0;
      fetch_ready = 0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " commit"}, 32'(cp0_commit), 0);
      check({tag, " epc_we"}, 32'(cp0_epc_we), 0);
      check({tag, " code"}, 32'(cp0_code), 0);
      check({tag, " epc"}, cp0_epc, 0);
      check({tag, " bd"}, 32'(cp0_bd), 0);
      check({tag, " clr_exl"}, 32'(cp0_clr_exl), 0);
      check({tag, " flush"}, 32'(flush), 0);
      check({tag, " stall"}, 32'(stall), 0);
      check({tag, " redir_valid"}, 32'(redir_valid), 0);
      check({tag, " redir_addr"}, redir_addr, 0);
      check({tag, " count"}, 32'(exc_count), 0);
   endtask

   task automatic run_vec(input vec_t v);
      exc_valid = v.ev; exc_code = v.code; exc_pc = v.pc; exc_in_delay = v.bd;
      int_req = v.irq; status_ie = v.ie; status_exl = v.exl; eret_req = v.eret;
      epc_in = v.epc_in;
      step();
      idle_inputs();
      if (v.kind == 0) begin
         check({v.name, " ignored stall"}, 32'(stall), 0);
         check({v.name, " ignored commit"}, 32'(cp0_commit), 0);
         check({v.name, " ignored clr_exl"}, 32'(cp0_clr_exl), 0);
         return;
      end
      if (v.kind == 1 && exp_count != '1) exp_count++;
      check({v.name, " T+1 commit"}, 32'(cp0_commit), (v.kind == 1) ? 1 : 0);
      check({v.name, " T+1 clr_exl"}, 32'(cp0_clr_exl), (v.kind == 2) ? 1 : 0);
      check({v.name, " T+1 flush"}, 32'(flush), 1);
      if (v.kind == 1) begin
         check({v.name, " code"}, 32'(cp0_code), 32'(v.e_code));
         check({v.name, " epc"}, cp0_epc, v.e_epc);
         check({v.name, " bd"}, 32'(cp0_bd), 32'(v.e_bd));
         check({v.name, " epc_we"}, 32'(cp0_epc_we), 32'(v.e_we));
      end
      check({v.name, " count"}, 32'(exc_count), 32'(exp_count));
      step();
      check({v.name, " T+2 flush"}, 32'(flush), 1);
      check({v.name, " T+2 commit"}, 32'(cp0_commit), 0);
      check({v.name, " T+2 redir_valid"}, 32'(redir_valid), 0);
      step();
      check({v.name, " redir_valid"}, 32'(redir_valid), 1);
      check({v.name, " redir_addr"}, redir_addr, v.e_target);
      check({v.name, " redir flush"}, 32'(flush), 0);
      check({v.name, " redir stall"}, 32'(stall), 1);
      fetch_ready = 1;
      step();
      fetch_ready = 0;
      check({v.name, " back idle"}, 32'(redir_valid), 0);
      check({v.name, " back stall"}, 32'(stall), 0);
   endtask

   initial begin
      vec_t v;
      idle_inputs();
      reset = 0;
      exp_count = '0;
      step(); step();
      check_all_zero("reset");
      reset = 1;
      step();

      //             name       ev code   pc            bd irq ie exl eret epc_in        kind e_code e_epc         e_bd we target
      vecs.push_back('{"exc",    1, 5'h04, 32'h0040_0010, 0, 0, 0, 0, 0, 32'h0,          1, 5'h04, 32'h0040_0010, 0, 1, VEC});
      vecs.push_back('{"exc_bd", 1, 5'h04, 32'h0040_0014, 1, 0, 0, 0, 0, 32'h0,          1, 5'h04, 32'h0040_0010, 1, 1, VEC});
      vecs.push_back('{"prio",   1, 5'h0C, 32'h0040_0030, 0, 1, 1, 0, 1, 32'h0040_0099, 1, 5'h0C, 32'h0040_0030, 0, 1, VEC});
      vecs.push_back('{"eret",   0, 5'h00, 32'h0,         0, 0, 0, 1, 1, 32'h0040_0020, 2, 5'h0C, 32'h0,         0, 0, 32'h0040_0020});
      vecs.push_back('{"int_exl",0, 5'h00, 32'h0040_0044, 0, 1, 1, 1, 0, 32'h0,          0, 5'h00, 32'h0,         0, 0, 32'h0});
      vecs.push_back('{"exc_exl",1, 5'h08, 32'h0040_0040, 0, 0, 0, 1, 0, 32'h0,          1, 5'h08, 32'h0040_0040, 0, 0, VEC});
      vecs.push_back('{"int",    0, 5'h1F, 32'h0040_0050, 0, 1, 1, 0, 0, 32'h0,          1, 5'h00, 32'h0040_0050, 0, 1, VEC});
      vecs.push_back('{"int_ie0",0, 5'h00, 32'h0040_0060, 0, 1, 0, 0, 0, 32'h0,          0, 5'h00, 32'h0,         0, 0, 32'h0});
      vecs.push_back('{"wrap",   1, 5'h0A, 32'h0000_0000, 1, 0, 0, 0, 0, 32'h0,          1, 5'h0A, 32'hFFFF_FFFC, 1, 1, VEC});
      vecs.push_back('{"int_bd", 0, 5'h00, 32'h0040_0074, 1, 1, 1, 0, 0, 32'h0,          1, 5'h00, 32'h0040_0070, 1, 1, VEC});

      foreach (vecs[i]) run_vec(vecs[i]);

      // ERET with fetch back-pressure: redirect must stay stable until accepted.
      eret_req = 1; epc_in = 32'h0040_0020;
      step();
      idle_inputs();
      epc_in = 32'h1234_5678;
      check("bp clr_exl", 32'(cp0_clr_exl), 1);
      step();
      check("bp clr_exl pulse", 32'(cp0_clr_exl), 0);
      step();
      for (int i = 0; i < 3; i++) begin
         check("bp redir_valid held", 32'(redir_valid), 1);
         check("bp redir_addr held", redir_addr, 32'h0040_0020);
         step();
      end
      check("bp count unchanged", 32'(exc_count), 32'(exp_count));
      // Transfer, then a request in the following IDLE cycle.
      fetch_ready = 1;
      check("bp still valid", 32'(redir_valid), 1);
      step();
      fetch_ready = 0;
      check("bp idle after xfer", 32'(redir_valid), 0);
      check("bp addr holds", redir_addr, 32'h0040_0020);
      exc_valid = 1; exc_code = 5'h0D; exc_pc = 32'h0040_0100;
      step();
      idle_inputs();
      check("b2b commit", 32'(cp0_commit), 1);
      check("b2b code", 32'(cp0_code), 32'h0D);
      // Reset lands during FLUSH: sequence abandoned, everything clears.
      reset = 0;
      step();
      reset = 1;
      exp_count = '0;
      check_all_zero("abort");
      step();
      check("abort stays idle", 32'(stall), 0);

      // Saturation: drive the counter to all-ones, then one more exception.
      v = vecs[0];
      v.name = "sat";
      for (int i = 0; i < 16; i++) run_vec(v);
      check("sat count", 32'(exc_count), 32'hF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
